// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry defaults, coordinate type,
// platform-manager state encoding, LFSR mask and helper functions.
// Used by platform_manager, the collision detector and doodle physics.
package game_pkg;

  localparam int unsigned SCREEN_WIDTH_DEF  = 400;
  localparam int unsigned SCREEN_HEIGHT_DEF = 700;
  localparam int unsigned BLOCK_WIDTH_DEF   = 40;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [31:0] coord_t;

  typedef enum logic [1:0] {
    PM_INIT,
    PM_IDLE,
    PM_SCROLL,
    PM_SPAWN
  } pm_state_t;

  // Galois step: shift right, fold the mask in when the dropped bit is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Folds a 9-bit random value into 0..xmax; values past xmax wrap to the left edge.
  function automatic coord_t map_x(input logic [8:0] r, input coord_t xmax);
    coord_t rw;
    rw = coord_t'(r);
    return (rw > xmax) ? (rw - xmax - 32'd1) : rw;
  endfunction

endpackage

// File: rtl/platform_manager_free_slot_finder.sv
// free_slot_finder: combinational priority encoder returning the lowest
// index whose active flag is clear.
//  active [N-1:0]  in   per-slot live flag
//  found           out  at least one slot is free
//  index [IW-1:0]  out  lowest free slot (0 when none)
module free_slot_finder #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  active,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!active[i] && !found) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/platform_manager.sv
// platform_manager: owns the platform table (X, Y, active per slot).
// Builds the initial layout after reset, scrolls platforms down on request,
// retires those falling below y=0 and spawns new ones above the highest.
//  clk, rst_n              clock, async active-low reset
//  tick                    frame pulse, triggers a spawn check in IDLE
//  scroll_req/scroll_amt   scroll handshake request and amount
//  scroll_ack              1-cycle accept pulse
//  blocks_x/blocks_y       per-slot coordinates
//  block_active            per-slot live flag
//  table_valid             table is stable (IDLE only)
//  top_y                   Y of highest active platform
//  scroll_total            saturating accumulated scroll
module platform_manager
  import game_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int unsigned BLOCK_WIDTH   = BLOCK_WIDTH_DEF,
  parameter int unsigned NUM_SLOTS     = 16,
  parameter int unsigned SPAWN_GAP     = 60,
  parameter int unsigned INIT_BASE_Y   = 20,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        scroll_req,
  input  logic [9:0]                  scroll_amt,
  output logic                        scroll_ack,
  output logic [NUM_SLOTS-1:0][31:0]  blocks_x,
  output logic [NUM_SLOTS-1:0][31:0]  blocks_y,
  output logic [NUM_SLOTS-1:0]        block_active,
  output logic                        table_valid,
  output logic [31:0]                 top_y,
  output logic [31:0]                 scroll_total
);

  localparam int unsigned  IW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam coord_t       XMAX   = coord_t'(SCREEN_WIDTH - BLOCK_WIDTH);
  localparam coord_t       HEIGHT = coord_t'(SCREEN_HEIGHT);
  localparam coord_t       GAP    = coord_t'(SPAWN_GAP);
  localparam coord_t       BASE_Y = coord_t'(INIT_BASE_Y);
  localparam logic [IW-1:0] LAST  = IW'(NUM_SLOTS - 1);

  pm_state_t     state, next_state;
  logic [IW-1:0] idx;
  coord_t        amt;
  logic [15:0]   lfsr;
  coord_t        lfsr_x;
  coord_t        init_y;
  coord_t        spawn_y;
  coord_t        cur_y;
  logic          spawn_ok;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [32:0]   total_sum;

  free_slot_finder #(.N(NUM_SLOTS), .IW(IW)) u_finder (
    .active (block_active),
    .found  (free_found),
    .index  (free_idx)
  );

  assign lfsr_x      = map_x(lfsr[8:0], XMAX);
  assign init_y      = BASE_Y + coord_t'(idx) * GAP;
  assign spawn_y     = top_y + GAP;
  assign cur_y       = blocks_y[idx];
  assign total_sum   = {1'b0, scroll_total} + 33'(scroll_amt);
  assign table_valid = (state == PM_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PM_INIT;
      lfsr  <= LFSR_SEED;
    end else begin
      state <= next_state;
      lfsr  <= lfsr_step(lfsr);
    end
  end

  always_comb begin
    next_state = state;
    scroll_ack = 1'b0;
    spawn_ok   = 1'b0;
    case (state)
      PM_INIT:   if (idx == LAST) next_state = PM_IDLE;
      PM_IDLE: begin
        if (scroll_req) begin
          scroll_ack = 1'b1;
          next_state = (scroll_amt == 10'd0) ? PM_SPAWN : PM_SCROLL;
        end else if (tick) begin
          next_state = PM_SPAWN;
        end
      end
      PM_SCROLL: if (idx == LAST) next_state = PM_SPAWN;
      PM_SPAWN: begin
        spawn_ok = (spawn_y <= HEIGHT) && free_found;
        if (!spawn_ok) next_state = PM_IDLE;
      end
      default:   next_state = PM_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      amt          <= '0;
      blocks_x     <= '0;
      blocks_y     <= '0;
      block_active <= '0;
      top_y        <= '0;
      scroll_total <= '0;
    end else begin
      case (state)
        PM_INIT: begin
          // Y rises with idx, so the last active slot written leaves top_y at the highest.
          if (init_y <= HEIGHT) begin
            block_active[idx] <= 1'b1;
            blocks_y[idx]     <= init_y;
            blocks_x[idx]     <= (idx == '0) ? (XMAX >> 1) : lfsr_x;
            top_y             <= init_y;
          end else begin
            block_active[idx] <= 1'b0;
            blocks_y[idx]     <= '0;
            blocks_x[idx]     <= '0;
          end
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        PM_IDLE: begin
          if (scroll_ack) begin
            amt          <= coord_t'(scroll_amt);
            scroll_total <= total_sum[32] ? '1 : total_sum[31:0];
            idx          <= '0;
          end
        end
        PM_SCROLL: begin
          if (idx == '0) top_y <= (top_y < amt) ? '0 : top_y - amt;
          if (block_active[idx]) begin
            if (cur_y < amt) begin
              block_active[idx] <= 1'b0;
              blocks_y[idx]     <= '0;
              blocks_x[idx]     <= '0;
            end else begin
              blocks_y[idx] <= cur_y - amt;
            end
          end
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        PM_SPAWN: begin
          if (spawn_ok) begin
            block_active[free_idx] <= 1'b1;
            blocks_y[free_idx]     <= spawn_y;
            blocks_x[free_idx]     <= lfsr_x;
            top_y                  <= spawn_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
